// File: rtl/slow_mult_acc.sv
// Shift-and-add multiply-accumulate: prod = A*B + C over W fixed iterations.
// Shares the start/valid handshake of the slow restoring divider so one controller can drive both.
module slow_mult_acc #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    input  logic [W-1:0]     C,
    output logic             busy,
    output logic             valid,
    output logic [2*W-1:0]   prod
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [2*W-1:0]    acc_r;
    logic [2*W-1:0]    mcand_r;
    logic [W-1:0]      mplier_r;
    logic [CW-1:0]     cnt_r;
    logic              busy_r;
    logic              valid_r;
    logic [2*W-1:0]    prod_r;
    logic [2*W-1:0]    acc_next_s;

    assign busy  = busy_r;
    assign valid = valid_r;
    assign prod  = prod_r;

    // Partial-product add for the current multiplier bit.
    always_comb begin
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Control FSM and datapath registers; outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            acc_r    <= {(2*W){1'b0}};
            mcand_r  <= {(2*W){1'b0}};
            mplier_r <= {W{1'b0}};
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
            prod_r   <= {(2*W){1'b0}};
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        acc_r    <= {{W{1'b0}}, C};
                        mcand_r  <= {{W{1'b0}}, A};
                        mplier_r <= B;
                        cnt_r    <= {CW{1'b0}};
                        valid_r  <= 1'b0;
                        busy_r   <= 1'b1;
                        state_r  <= CALC;
                    end else begin
                        state_r  <= state_r;
                    end
                end
                CALC: begin
                    // start is deliberately ignored here so the operation in flight completes.
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + CW'(1);
                    if (cnt_r == CNT_LAST) begin
                        prod_r  <= acc_next_s;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= DONE;
                    end else begin
                        state_r <= CALC;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
